// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: performs a WORD_W*NUM_WORDS-bit addition on one shared
// WORD_W-bit adder that lives outside this block. Each RUN cycle feeds one word
// (least significant first) and captures one word of the sum. The carry out of
// each word is fed back as the carry in of the next word.
module wide_add_sequencer #(
  parameter int WORD_W    = 64,
  parameter int NUM_WORDS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  // request side
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [WORD_W*NUM_WORDS-1:0] req_a,
  input  logic [WORD_W*NUM_WORDS-1:0] req_b,
  input  logic                        req_cin,
  // shared adder
  output logic [WORD_W-1:0]           add_in1,
  output logic [WORD_W-1:0]           add_in2,
  output logic                        add_cin,
  input  logic [WORD_W-1:0]           add_sum,
  input  logic                        add_cout,
  // response side
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [WORD_W*NUM_WORDS-1:0] rsp_sum,
  output logic                        rsp_cout
);

  localparam int W     = WORD_W * NUM_WORDS;
  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, b_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic             last_word;

  assign last_word = (idx_q == LAST_IDX);

  // State register; reset takes priority over any handshake on the same edge.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, handshake flags and adder drive; the adder sees zeros outside RUN.
  // NOTE: every output gets a default before the case, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    add_in1   = '0;
    add_in2   = '0;
    add_cin   = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = RUN;
      end
      RUN: begin
        add_in1 = a_q[int'(idx_q)*WORD_W +: WORD_W];
        add_in2 = b_q[int'(idx_q)*WORD_W +: WORD_W];
        add_cin = carry_q;
        if (last_word) state_d = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture at accept; these are only read in RUN, after a fresh load.
  // NOTE: wide data registers are deliberately left without reset: their
  // contents are never observed before an accept overwrites them.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && req_valid) begin
      a_q <= req_a;
      b_q <= req_b;
    end
  end

  // Carry chain, word index and result accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q  <= 1'b0;
      idx_q    <= '0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            carry_q <= req_cin;
            idx_q   <= '0;
            rsp_sum <= '0;
          end
        end
        RUN: begin
          rsp_sum[int'(idx_q)*WORD_W +: WORD_W] <= add_sum;
          carry_q <= add_cout;
          if (last_word) rsp_cout <= add_cout;
          else           idx_q    <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Testbench for wide_add_sequencer at WORD_W=64, NUM_WORDS=4. The shared adder
// is modelled here as a plain combinational 64-bit add with carry.
module tb_wide_add_sequencer;

  localparam int WORD_W    = 64;
  localparam int NUM_WORDS = 4;
  localparam int W         = WORD_W * NUM_WORDS;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [W-1:0]      req_a, req_b;
  logic              req_cin;
  logic [WORD_W-1:0] add_in1, add_in2, add_sum;
  logic              add_cin, add_cout;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;

  int checks = 0;
  int errors = 0;

  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] ALT_A = {(W/4){4'hA}};
  localparam logic [W-1:0] ALT_B = {(W/4){4'h5}};

  always #5 clk = ~clk;

  // External shared adder.
  assign {add_cout, add_sum} = {1'b0, add_in1} + {1'b0, add_in2} + {{WORD_W{1'b0}}, add_cin};

  wide_add_sequencer #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .add_in1   (add_in1),
    .add_in2   (add_in2),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  function automatic logic [W:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] v;
    for (int i = 0; i < W/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request until accepted; ok=0 if req_ready never rose.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      output bit ok);
    int n = 0;
    req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1;
    while (!req_ready && n < 50) begin tick(); n++; end
    ok = req_ready;
    tick();
    req_valid = 1'b0;
  endtask

  // Count clock edges until rsp_valid is high (bounded).
  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         output logic [W:0] res, output bit ok);
    int n;
    bit sent;
    send(a, b, cin, sent);
    wait_rsp(n);
    ok  = sent && rsp_valid;
    res = {rsp_cout, rsp_sum};
    consume();
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_cin = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++;
    if ({rsp_cout, rsp_sum} !== '0) begin errors++; $display("FAIL reset_rsp: got %h expected 0", {rsp_cout, rsp_sum}); end
    checks++;
    if ({add_in1, add_in2, add_cin} !== '0) begin errors++; $display("FAIL reset_adder_idle: got %h/%h/%b expected zeros", add_in1, add_in2, add_cin); end
  endtask

  task automatic test_zero_latency();
    bit ok;
    int n;
    send('0, '0, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL zero_accept: req_ready never rose"); end
    wait_rsp(n);
    // accept cycle counts as cycle 0; rsp_valid must first appear in cycle 5
    checks++;
    if (n + 1 !== 5) begin errors++; $display("FAIL zero_latency: got %0d cycles expected 5", n + 1); end
    checks++;
    if ({rsp_cout, rsp_sum} !== '0) begin errors++; $display("FAIL zero_sum: got %h expected 0", {rsp_cout, rsp_sum}); end
    checks++;
    if ({add_in1, add_in2, add_cin} !== '0) begin errors++; $display("FAIL done_adder_idle: got %h/%h/%b expected zeros", add_in1, add_in2, add_cin); end
    consume();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL zero_handshake: got valid=%b ready=%b expected 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_carry_ripple();
    bit ok;
    logic [3:0] cin_seen;
    logic [WORD_W-1:0] in1_first, in2_first;
    send(ONES, 256'd1, 1'b0, ok);
    in1_first = add_in1;
    in2_first = add_in2;
    for (int i = 0; i < 4; i++) begin
      cin_seen[i] = add_cin;
      tick();
    end
    checks++;
    if (!ok || in1_first !== {WORD_W{1'b1}} || in2_first !== 64'd1) begin
      errors++; $display("FAIL ripple_word0: got %h/%h expected ffff_ffff_ffff_ffff/1", in1_first, in2_first);
    end
    checks++;
    if (cin_seen !== 4'b1110) begin errors++; $display("FAIL ripple_add_cin: got %b expected 1110", cin_seen); end
    checks++;
    if (rsp_valid !== 1'b1 || {rsp_cout, rsp_sum} !== {1'b1, {W{1'b0}}}) begin
      errors++; $display("FAIL ripple_sum: got valid=%b %h expected valid=1 1 followed by zeros", rsp_valid, {rsp_cout, rsp_sum});
    end
    consume();
  endtask

  task automatic test_alternating();
    logic [W:0] res;
    bit ok;
    run_one(ALT_A, ALT_B, 1'b1, res, ok);
    checks++;
    if (!ok || res !== {1'b1, {W{1'b0}}}) begin errors++; $display("FAIL alt_cin1: got %h expected carry 1 sum 0", res); end
    run_one(ALT_A, ALT_B, 1'b0, res, ok);
    checks++;
    if (!ok || res !== {1'b0, ONES}) begin errors++; $display("FAIL alt_cin0: got %h expected carry 0 sum all-ones", res); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n;
    logic [W-1:0] msb;
    msb = '0;
    msb[W-1] = 1'b1;
    send(msb, msb, 1'b0, ok);
    wait_rsp(n);
    checks++;
    if (!ok || rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_response: got valid=%b expected 1", rsp_valid); end
    req_a = 256'd3; req_b = 256'd4; req_cin = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || {rsp_cout, rsp_sum} !== {1'b1, {W{1'b0}}}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b ready=%b rsp=%h expected 1/0 carry 1 sum 0", i, rsp_valid, req_ready, {rsp_cout, rsp_sum});
      end
      tick();
    end
    consume();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got ready=%b valid=%b expected 1/0", req_ready, rsp_valid); end
    tick();
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_held_accept: got ready=%b expected 0", req_ready); end
    wait_rsp(n);
    checks++;
    if (rsp_valid !== 1'b1 || {rsp_cout, rsp_sum} !== 257'd7) begin errors++; $display("FAIL bp_held_sum: got valid=%b %h expected 1 and 7", rsp_valid, {rsp_cout, rsp_sum}); end
    consume();
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    logic [W:0] res;
    send(ONES, ONES, 1'b0, ok);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_run_flags: got valid=%b ready=%b expected 0/1", rsp_valid, req_ready); end
    checks++;
    if ({rsp_cout, rsp_sum} !== '0 || {add_in1, add_in2, add_cin} !== '0) begin
      errors++; $display("FAIL rst_run_clear: got rsp=%h in1=%h cin=%b expected zeros", {rsp_cout, rsp_sum}, add_in1, add_cin);
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_run_discard: got valid=%b expected 0", rsp_valid); end
    run_one(256'd1, 256'd1, 1'b1, res, ok);
    checks++;
    if (!ok || res !== 257'd3) begin errors++; $display("FAIL rst_run_next: got %h expected 3", res); end
  endtask

  task automatic test_back_to_back();
    logic [W:0] exp_q[$];
    logic [W:0] exp_v;
    int sent = 0, got = 0, cyc = 0, last_hs = -1;
    bit acc;
    rsp_ready = 1'b1;
    req_a = rand_wide(); req_b = rand_wide(); req_cin = 1'($urandom_range(0, 1));
    req_valid = 1'b1;
    while (got < 200 && cyc < 200*6 + 100) begin
      acc = req_valid && req_ready;
      if (acc) exp_q.push_back(golden(req_a, req_b, req_cin));
      if (rsp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected: got response %h expected none", {rsp_cout, rsp_sum});
        end else begin
          exp_v = exp_q.pop_front();
          if ({rsp_cout, rsp_sum} !== exp_v) begin
            errors++; $display("FAIL b2b_sum[%0d]: got %h expected %h", got, {rsp_cout, rsp_sum}, exp_v);
          end
        end
        if (last_hs >= 0) begin
          checks++;
          if (cyc - last_hs !== 6) begin errors++; $display("FAIL b2b_period[%0d]: got %0d expected 6", got, cyc - last_hs); end
        end
        last_hs = cyc;
        got++;
      end
      tick();
      cyc++;
      if (acc) begin
        sent++;
        if (sent < 200) begin
          req_a = rand_wide(); req_b = rand_wide(); req_cin = 1'($urandom_range(0, 1));
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    rsp_ready = 1'b0;
    checks++;
    if (got !== 200) begin errors++; $display("FAIL b2b_count: got %0d expected 200", got); end
  endtask

  initial begin
    test_reset();
    test_zero_latency();
    test_carry_ripple();
    test_alternating();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
